// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers and limits for the Gray counter family.
// Functions operate on MAX_WIDTH vectors; narrower values are zero-extended by the caller.
package gray_pkg;

  localparam int MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] b2g(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits contribute nothing to the running XOR, so any width <= MAX_WIDTH works.
  function automatic logic [MAX_WIDTH-1:0] g2b(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    logic                 acc;
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_conv.sv
// Purely combinational WIDTH-bit Gray-to-binary converter.
// Used on the Gray load path of gray_counter and reusable behind synchronisers.
module gray_to_bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  always_comb begin
    bin_out = WIDTH'(g2b(MAX_WIDTH'(gray_in)));
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code twin, wrap pulse and end flags.
// Define GRAY_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_conv;
  logic [WIDTH-1:0] load_bin;

  gray_to_bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .gray_in (load_val),
    .bin_out (load_conv)
  );

  // Gray is derived from the next binary value so both registers update on the same edge.
  always_comb begin
    load_bin = load_is_gray ? load_conv : load_val;
    bin_d    = bin_q;
    wrap_d   = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (bin_q == ALL_ONES) begin
          wrap_d = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
          bin_d  = bin_q;
`else
          bin_d  = '0;
`endif
        end else begin
          bin_d = bin_q + ONE;
        end
      end else begin
        if (bin_q == '0) begin
          wrap_d = 1'b1;
`ifdef GRAY_COUNTER_SATURATE_EN
          bin_d  = bin_q;
`else
          bin_d  = ALL_ONES;
`endif
        end else begin
          bin_d = bin_q - ONE;
        end
      end
    end
    gray_d = WIDTH'(b2g(MAX_WIDTH'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin    = bin_q;
  assign gray   = gray_q;
  assign wrap   = wrap_q;
  assign at_max = (bin_q == ALL_ONES);
  assign at_min = (bin_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=5 with RESET_VAL 0 and 5 instances.
// Expected responses are queued at stimulus time and popped by a monitor each cycle.
module tb_gray_counter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, en, up, load, load_is_gray;
  logic [W-1:0] load_val;
  logic [W-1:0] bin, gray, bin5, gray5;
  logic         wrap, at_max, at_min, wrap5, at_max5, at_min5;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic [W-1:0] bin5;
    logic [W-1:0] gray5;
    logic         wrap5;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] m_bin, m_bin5;
  logic         m_wrap, m_wrap5;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .RESET_VAL(5'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin(bin), .gray(gray), .wrap(wrap), .at_max(at_max), .at_min(at_min)
  );

  gray_counter #(.WIDTH(W), .RESET_VAL(5'd5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin(bin5), .gray(gray5), .wrap(wrap5), .at_max(at_max5), .at_min(at_min5)
  );

  function automatic logic [W-1:0] toGray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] fromGray(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic modelStep(input logic r, e, u, l, lg, input logic [W-1:0] lv,
                           input logic [W-1:0] rv, inout logic [W-1:0] b, output logic w);
    w = 1'b0;
    if (r) b = rv;
    else if (l) b = lg ? fromGray(lv) : lv;
    else if (e) begin
      if (u && b == 5'd31) begin
        w = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
        b = 5'd0;
`endif
      end else if (!u && b == 5'd0) begin
        w = 1'b1;
`ifndef GRAY_COUNTER_SATURATE_EN
        b = 5'd31;
`endif
      end else begin
        b = u ? b + 5'd1 : b - 5'd1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic r, e, u, l, lg, input logic [W-1:0] lv);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_is_gray = lg; load_val = lv;
    modelStep(r, e, u, l, lg, lv, 5'd0, m_bin, m_wrap);
    modelStep(r, e, u, l, lg, lv, 5'd5, m_bin5, m_wrap5);
    x.bin  = m_bin;  x.gray  = toGray(m_bin);  x.wrap  = m_wrap;
    x.bin5 = m_bin5; x.gray5 = toGray(m_bin5); x.wrap5 = m_wrap5;
    sb.push_back(x);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every cycle the DUT presents a fresh registered result one step after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("sb_bin",    32'(bin),     32'(e.bin));
      checkOutput("sb_gray",   32'(gray),    32'(e.gray));
      checkOutput("sb_wrap",   32'(wrap),    32'(e.wrap));
      checkOutput("sb_at_max", 32'(at_max),  32'(e.bin == 5'd31));
      checkOutput("sb_at_min", 32'(at_min),  32'(e.bin == 5'd0));
      checkOutput("sb_bin5",   32'(bin5),    32'(e.bin5));
      checkOutput("sb_gray5",  32'(gray5),   32'(e.gray5));
      checkOutput("sb_wrap5",  32'(wrap5),   32'(e.wrap5));
    end
  end

  initial begin
    int wraps;
    int guard;
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_is_gray = 1'b0; load_val = '0;
    m_bin = '0; m_bin5 = '0; m_wrap = 1'b0; m_wrap5 = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 5'd0);
    afterEdge();
    checkOutput("hand_reset_bin",   32'(bin),   32'h0);
    checkOutput("hand_reset_gray",  32'(gray),  32'h0);
    checkOutput("hand_reset_at_min", 32'(at_min), 32'h1);
    checkOutput("hand_reset5_bin",  32'(bin5),  32'h5);
    checkOutput("hand_reset5_gray", 32'(gray5), 32'b00111);

    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 5'd0);
      afterEdge();
      if (wrap) wraps++;
    end
`ifndef GRAY_COUNTER_SATURATE_EN
    checkOutput("hand_count32_bin", 32'(bin), 32'h0);
    checkOutput("hand_count32_wraps", 32'(wraps), 32'h1);

    applyStimulus(0, 0, 0, 0, 0, 5'd0);
    applyStimulus(0, 1, 0, 0, 0, 5'd0);
    afterEdge();
    checkOutput("hand_down_bin",    32'(bin),    32'd31);
    checkOutput("hand_down_gray",   32'(gray),   32'b10000);
    checkOutput("hand_down_wrap",   32'(wrap),   32'h1);
    checkOutput("hand_down_at_max", 32'(at_max), 32'h1);
`endif

    applyStimulus(0, 0, 0, 1, 1, 5'b10000);
    afterEdge();
    checkOutput("hand_gload1_bin",  32'(bin),  32'b11111);
    checkOutput("hand_gload1_gray", 32'(gray), 32'b10000);
    applyStimulus(0, 0, 0, 1, 1, 5'b11111);
    afterEdge();
    checkOutput("hand_gload2_bin",  32'(bin),  32'b10101);
    checkOutput("hand_gload2_gray", 32'(gray), 32'b11111);

    applyStimulus(0, 1, 1, 1, 0, 5'b00111);
    afterEdge();
    checkOutput("hand_bload_bin",  32'(bin),  32'd7);
    checkOutput("hand_bload_gray", 32'(gray), 32'b00100);
    checkOutput("hand_bload_wrap", 32'(wrap), 32'h0);

    applyStimulus(0, 0, 0, 1, 0, 5'd31);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 5'd0);
`ifdef GRAY_COUNTER_SATURATE_EN
      afterEdge();
      checkOutput("hand_sat_bin",  32'(bin),  32'd31);
      checkOutput("hand_sat_wrap", 32'(wrap), 32'h1);
      checkOutput("hand_sat_gray", 32'(gray), 32'b10000);
`endif
    end

    applyStimulus(0, 0, 0, 1, 0, 5'd12);
    applyStimulus(0, 1, 1, 0, 0, 5'd0);
    applyStimulus(1, 1, 1, 0, 0, 5'd0);
    afterEdge();
    checkOutput("hand_midrst_bin",   32'(bin),   32'h0);
    checkOutput("hand_midrst_gray",  32'(gray),  32'h0);
    checkOutput("hand_midrst_wrap",  32'(wrap),  32'h0);
    checkOutput("hand_midrst5_bin",  32'(bin5),  32'h5);
    checkOutput("hand_midrst5_gray", 32'(gray5), 32'b00111);
    applyStimulus(0, 1, 1, 0, 0, 5'd0);
    applyStimulus(0, 1, 1, 0, 0, 5'd0);

    applyStimulus(1, 1, 1, 1, 1, 5'd9);
    applyStimulus(0, 1, 0, 0, 0, 5'd0);
    applyStimulus(0, 1, 1, 0, 0, 5'd0);
    applyStimulus(0, 1, 0, 0, 0, 5'd0);
    applyStimulus(0, 0, 1, 0, 0, 5'd0);

    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (sb.size() != 0) begin
      checkOutput("sb_drain_timeout", 32'(sb.size()), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
